// File: rtl/fpu_issuer_if.sv
// rtl/fpu_issuer_if.sv - request, response and FPU-side signal bundle for fpu_issuer
interface fpu_issuer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [CW-1:0] pending;
    logic          fpu_en;
    logic [31:0]   fpu_adata;
    logic [31:0]   fpu_bdata;
    logic [31:0]   fpu_result;
    logic          fpu_done;
    logic          fpu_busy;

    // slave is the issuer itself; master is the requester plus the FPU unit
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, fpu_result, fpu_done, fpu_busy,
        output req_ready, rsp_valid, rsp_data, rsp_err, pending, fpu_en, fpu_adata, fpu_bdata
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, fpu_result, fpu_done, fpu_busy,
        input  req_ready, rsp_valid, rsp_data, rsp_err, pending, fpu_en, fpu_adata, fpu_bdata
    );
endinterface

// File: rtl/fpu_issuer.sv
// rtl/fpu_issuer.sv - queued single-in-flight FPU operation issuer with completion timeout
module fpu_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    fpu_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [63:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      tcnt;
    logic            push;
    logic            issue;

    assign bus.req_ready = (count < CW'(DEPTH));
    assign bus.pending   = count;
    assign push          = bus.req_valid & bus.req_ready;
    // the output register must be free (or draining this edge) before a new op starts
    assign issue = (state == IDLE) && (count != '0) && !bus.fpu_busy &&
                   (!bus.rsp_valid || bus.rsp_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.req_a, bus.req_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tcnt          <= '0;
            bus.fpu_en    <= 1'b0;
            bus.fpu_adata <= '0;
            bus.fpu_bdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.fpu_en <= 1'b0;
            if (bus.rsp_valid && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(issue);

            case (state)
                IDLE: begin
                    if (issue) begin
                        bus.fpu_en    <= 1'b1;
                        bus.fpu_adata <= mem[rd_ptr][63:32];
                        bus.fpu_bdata <= mem[rd_ptr][31:0];
                        rd_ptr        <= rd_ptr + 1'b1;
                        tcnt          <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.fpu_done) begin
                        bus.rsp_data  <= bus.fpu_result;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= IDLE;
                    end else if ((tcnt + 8'd1) == 8'(TIMEOUT)) begin
                        bus.rsp_data  <= QNAN;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
